// File: rtl/abft_pkg.sv
// ============================================================================
//  Module      : abft_pkg
//  Description : Shared constants, FSM state type and index-width helper for
//                the full-checksum ABFT verifier.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package abft_pkg;

    localparam int DEF_N = 32;
    localparam int DEF_W = 32;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        CHECK   = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    // Width of a row/column index into an (n+1)-entry frame.
    function automatic int idx_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/abft_row_checker.sv
// ============================================================================
//  Module      : abft_row_checker
//  Description : Combinational row-checksum difference and mismatch flag.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module abft_row_checker
    import abft_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic [(N+1)*W-1:0] i_row,
    output logic [W-1:0]       o_rd,
    output logic               o_mismatch
);

    logic [W-1:0] w_sum;

    always_comb begin
        w_sum = '0;
        for (int j = 0; j < N; j++) begin
            w_sum = w_sum + i_row[j*W +: W];
        end
        o_rd       = w_sum - i_row[N*W +: W];
        o_mismatch = |o_rd;
    end

endmodule

`default_nettype wire

// File: rtl/abft_fc_verifier.sv
// ============================================================================
//  Module      : abft_fc_verifier
//  Description : Buffers one (N+1)x(N+1) full-checksum frame, classifies it
//                and drains it, optionally correcting a single faulty element.
//                Correction is enabled by defining ABFT_CORRECT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module abft_fc_verifier
    import abft_pkg::*;
#(
    parameter int N = DEF_N,
    parameter int W = DEF_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [(N+1)*W-1:0]        in_row,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [(N+1)*W-1:0]        out_row,
    output logic                      status_valid,
    output logic                      err_detected,
    output logic                      err_corrected,
    output logic                      err_uncorrectable,
    output logic [idx_width(N)-1:0]   err_row,
    output logic [idx_width(N)-1:0]   err_col
);

    localparam int c_idx_w = idx_width(N);
    typedef logic [c_idx_w-1:0] idx_t;
    localparam idx_t c_last = idx_t'(N);

`ifdef ABFT_CORRECT_EN
    localparam logic c_correct_en = 1'b1;
`else
    localparam logic c_correct_en = 1'b0;
`endif

    state_t                r_state;
    state_t                w_state_next;
    idx_t                  r_cnt;
    logic [(N+1)*W-1:0]    r_buf [0:N];
    logic [W-1:0]          r_acc [0:N];
    logic [W-1:0]          r_rd  [0:N];
    logic [W-1:0]          r_cd  [0:N];
    logic [N:0]            r_rmis;
    logic [N:0]            r_cmis;
    logic                  r_err_detected;
    logic                  r_err_corrected;
    logic                  r_err_uncorrectable;
    idx_t                  r_err_row;
    idx_t                  r_err_col;

    logic [W-1:0]          w_rd;
    logic                  w_rmis;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_last;
    logic                  w_clean;
    logic                  w_single;
    idx_t                  w_r;
    idx_t                  w_c;
    logic [W-1:0]          w_e;

    abft_row_checker #(
        .N (N),
        .W (W)
    ) u_row_checker (
        .i_row      (in_row),
        .o_rd       (w_rd),
        .o_mismatch (w_rmis)
    );

    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = out_valid & out_ready;
    assign w_last     = (r_cnt == c_last);
    assign out_row    = r_buf[r_cnt];

    assign err_detected      = r_err_detected;
    assign err_corrected     = r_err_corrected;
    assign err_uncorrectable = r_err_uncorrectable;
    assign err_row           = r_err_row;
    assign err_col           = r_err_col;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= COLLECT;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Handshake outputs are masked by rst so nothing moves while it is high.
    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        status_valid = 1'b0;
        case (r_state)
            COLLECT: begin
                in_ready = !rst;
                if (in_valid && w_last) begin
                    w_state_next = CHECK;
                end
            end
            CHECK: begin
                w_state_next = DRAIN;
            end
            DRAIN: begin
                out_valid    = !rst;
                status_valid = !rst;
                if (out_ready && w_last) begin
                    w_state_next = COLLECT;
                end
            end
            default: begin
                w_state_next = COLLECT;
            end
        endcase
    end

    // Frame classification and correction amount from the mismatch vectors.
    always_comb begin
        w_r = '0;
        w_c = '0;
        for (int i = 0; i <= N; i++) begin
            if (r_rmis[i]) w_r = idx_t'(i);
            if (r_cmis[i]) w_c = idx_t'(i);
        end
        w_clean  = (r_rmis == '0) && (r_cmis == '0);
        w_single = $onehot(r_rmis) && $onehot(r_cmis);
        if (w_c != c_last) begin
            w_e = r_rd[w_r];
        end else if (w_r != c_last) begin
            w_e = r_cd[w_c];
        end else begin
            w_e = '0 - r_rd[w_r];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt               <= '0;
            r_rmis              <= '0;
            r_cmis              <= '0;
            r_err_detected      <= 1'b0;
            r_err_corrected     <= 1'b0;
            r_err_uncorrectable <= 1'b0;
            r_err_row           <= '0;
            r_err_col           <= '0;
            for (int c = 0; c <= N; c++) begin
                r_acc[c] <= '0;
            end
        end else begin
            case (r_state)
                COLLECT: begin
                    if (w_in_fire) begin
                        r_buf[r_cnt]  <= in_row;
                        r_rd[r_cnt]   <= w_rd;
                        r_rmis[r_cnt] <= w_rmis;
                        if (w_last) begin
                            r_cnt <= '0;
                            for (int c = 0; c <= N; c++) begin
                                r_cd[c]   <= r_acc[c] - in_row[c*W +: W];
                                r_cmis[c] <= |(r_acc[c] - in_row[c*W +: W]);
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                            for (int c = 0; c <= N; c++) begin
                                r_acc[c] <= r_acc[c] + in_row[c*W +: W];
                            end
                        end
                    end
                end
                CHECK: begin
                    r_err_detected      <= !w_clean;
                    r_err_uncorrectable <= !w_clean && !w_single;
                    r_err_corrected     <= w_single && c_correct_en;
                    r_err_row           <= w_single ? w_r : '0;
                    r_err_col           <= w_single ? w_c : '0;
                    if (w_single && c_correct_en) begin
                        r_buf[w_r][w_c*W +: W] <= r_buf[w_r][w_c*W +: W] - w_e;
                    end
                end
                DRAIN: begin
                    if (w_out_fire) begin
                        if (w_last) begin
                            r_cnt               <= '0;
                            r_rmis              <= '0;
                            r_cmis              <= '0;
                            r_err_detected      <= 1'b0;
                            r_err_corrected     <= 1'b0;
                            r_err_uncorrectable <= 1'b0;
                            r_err_row           <= '0;
                            r_err_col           <= '0;
                            for (int c = 0; c <= N; c++) begin
                                r_acc[c] <= '0;
                            end
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_abft_fc_verifier.sv
// ============================================================================
//  Module      : tb_abft_fc_verifier
//  Description : Directed and random frames for abft_fc_verifier (N=4, W=8),
//                checked against a frame-level checksum model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_abft_fc_verifier;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 3;

`ifdef ABFT_CORRECT_EN
    localparam bit CORR = 1'b1;
`else
    localparam bit CORR = 1'b0;
`endif

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [(N+1)*W-1:0]   in_row = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b0;
    logic [(N+1)*W-1:0]   out_row;
    logic                 status_valid;
    logic                 err_detected;
    logic                 err_corrected;
    logic                 err_uncorrectable;
    logic [IW-1:0]        err_row;
    logic [IW-1:0]        err_col;

    abft_fc_verifier #(.N(N), .W(W)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .in_row            (in_row),
        .out_valid         (out_valid),
        .out_ready         (out_ready),
        .out_row           (out_row),
        .status_valid      (status_valid),
        .err_detected      (err_detected),
        .err_corrected     (err_corrected),
        .err_uncorrectable (err_uncorrectable),
        .err_row           (err_row),
        .err_col           (err_col)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int frame [0:N][0:N];
    int exp_m [0:N][0:N];
    int got   [0:N][0:N];
    int exp_det, exp_cor, exp_unc, exp_r, exp_c;
    int cap_det, cap_cor, cap_unc, cap_r, cap_c;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int m8(input int x);
        return ((x % 256) + 256) % 256;
    endfunction

    function automatic logic [(N+1)*W-1:0] pack_row(input int r, input bit use_exp);
        logic [(N+1)*W-1:0] v;
        for (int j = 0; j <= N; j++) begin
            v[j*W +: W] = use_exp ? 8'(exp_m[r][j]) : 8'(frame[r][j]);
        end
        return v;
    endfunction

    // Data rows random, checksum column and checksum row derived by plain sums.
    task automatic make_clean(input bit randomize_data);
        for (int r = 0; r < N; r++) begin
            int s = 0;
            for (int c = 0; c < N; c++) begin
                if (randomize_data) frame[r][c] = $urandom_range(0, 255);
                s += frame[r][c];
            end
            frame[r][N] = m8(s);
        end
        for (int c = 0; c <= N; c++) begin
            int s = 0;
            for (int r = 0; r < N; r++) s += frame[r][c];
            frame[N][c] = m8(s);
        end
    endtask

    task automatic make_seq();
        for (int r = 0; r < N; r++)
            for (int c = 0; c < N; c++)
                frame[r][c] = r * N + c + 1;
        make_clean(1'b0);
    endtask

    // Frame-level reference: checksum differences, classification, correction.
    task automatic model();
        int rd [0:N];
        int cd [0:N];
        int nr = 0, nc = 0, rr = 0, cc = 0, e;
        for (int r = 0; r <= N; r++) begin
            int s = 0;
            for (int j = 0; j < N; j++) s += frame[r][j];
            rd[r] = m8(s - frame[r][N]);
            if (rd[r] != 0) begin nr++; rr = r; end
        end
        for (int c = 0; c <= N; c++) begin
            int s = 0;
            for (int r = 0; r < N; r++) s += frame[r][c];
            cd[c] = m8(s - frame[N][c]);
            if (cd[c] != 0) begin nc++; cc = c; end
        end
        for (int r = 0; r <= N; r++)
            for (int c = 0; c <= N; c++)
                exp_m[r][c] = frame[r][c];
        exp_det = 0; exp_cor = 0; exp_unc = 0; exp_r = 0; exp_c = 0;
        if (nr == 1 && nc == 1) begin
            exp_det = 1; exp_r = rr; exp_c = cc; exp_cor = CORR;
            if (CORR) begin
                e = (cc < N) ? rd[rr] : (rr < N) ? cd[cc] : m8(-rd[rr]);
                exp_m[rr][cc] = m8(frame[rr][cc] - e);
            end
        end else if (nr != 0 || nc != 0) begin
            exp_det = 1; exp_unc = 1;
        end
    endtask

    // Entered and left at a falling edge.
    task automatic run_frame(input int stall_row);
        int b;
        model();
        for (int r = 0; r <= N; r++) begin
            in_valid = 1'b0;
            repeat ($urandom_range(0, 1)) @(negedge clk);
            in_valid = 1'b1;
            in_row   = pack_row(r, 1'b0);
            b = 0;
            while (!in_ready && b < 20) begin @(negedge clk); b++; end
            if (b == 20) chk("in_ready_timeout", 0, 1);
            @(posedge clk);
            @(negedge clk);
        end
        in_valid = 1'b1;
        in_row   = {$urandom, 8'(~$urandom_range(0, 255))};
        chk("check_out_valid", out_valid, 0);
        chk("check_in_ready", in_ready, 0);
        @(negedge clk);
        chk("latency_out_valid", out_valid, 1);
        for (int r = 0; r <= N; r++) begin
            out_ready = 1'b0;
            if (r == stall_row) begin
                repeat (5) begin
                    chk("stall_out_row", out_row, pack_row(r, 1'b1));
                    chk("stall_out_valid", out_valid, 1);
                    @(negedge clk);
                end
            end
            repeat ($urandom_range(0, 1)) @(negedge clk);
            b = 0;
            while (!out_valid && b < 20) begin @(negedge clk); b++; end
            if (b == 20) chk("out_valid_timeout", 0, 1);
            for (int j = 0; j <= N; j++) got[r][j] = out_row[j*W +: W];
            chk("out_row", out_row, pack_row(r, 1'b1));
            chk("status_valid", status_valid, 1);
            chk("drain_in_ready", in_ready, 0);
            if (r == 0) begin
                cap_det = err_detected; cap_cor = err_corrected; cap_unc = err_uncorrectable;
                cap_r = err_row; cap_c = err_col;
                chk("err_detected", err_detected, exp_det);
                chk("err_corrected", err_corrected, exp_cor);
                chk("err_uncorrectable", err_uncorrectable, exp_unc);
                chk("err_row", err_row, exp_r);
                chk("err_col", err_col, exp_c);
            end else begin
                chk("err_held", {err_detected, err_corrected, err_uncorrectable, err_row, err_col},
                    {exp_det[0], exp_cor[0], exp_unc[0], 3'(exp_r), 3'(exp_c)});
            end
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        chk("post_frame_in_ready", in_ready, 1);
        chk("post_frame_out_valid", out_valid, 0);
    endtask

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_status_valid", status_valid, 0);
        chk("rst_err_detected", err_detected, 0);
        rst = 1'b0;
        #1;
        chk("rst_release_in_ready", in_ready, 1);
        @(negedge clk);

        // Clean sequential frame
        make_seq();
        run_frame(-1);
        chk("clean_elem", got[1][2], 7);
        chk("clean_cksum", got[N][N], 136);

        // Single data error at (1,2): 7 -> 9
        make_seq();
        frame[1][2] = 9;
        run_frame(-1);
        chk("e12_row", cap_r, 1);
        chk("e12_col", cap_c, 2);
        chk("e12_elem", got[1][2], CORR ? 7 : 9);
        chk("e12_corrected", cap_cor, CORR);
        chk("e12_uncorr", cap_unc, 0);

        // Corner checksum corrupted by +3
        make_seq();
        frame[N][N] = m8(frame[N][N] + 3);
        run_frame(-1);
        chk("corner_elem", got[N][N], CORR ? 136 : 139);

        // Checksum column element (2,4) corrupted, with a mid-drain stall
        make_seq();
        frame[2][N] = 50;
        run_frame(2);
        chk("ckcol_elem", got[2][N], CORR ? 42 : 50);
        chk("ckcol_loc", {cap_r, cap_c}, {32'd2, 32'd4});

        // Two errors: uncorrectable, data untouched
        make_seq();
        frame[0][1] = 5;
        frame[2][3] = 1;
        run_frame(-1);
        chk("two_err_uncorr", cap_unc, 1);
        chk("two_err_elem", got[0][1], 5);

        // Wrap-around: 250 + 10 = 4
        make_seq();
        frame[0][0] = 250;
        make_clean(1'b0);
        frame[0][0] = 4;
        run_frame(-1);
        chk("wrap_elem", got[0][0], CORR ? 250 : 4);

        // Reset after row 2 accepted, then a fresh clean frame
        make_clean(1'b1);
        for (int r = 0; r <= 2; r++) begin
            in_valid = 1'b1;
            in_row   = pack_row(r, 1'b0);
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_in_ready", in_ready, 0);
        @(negedge clk);
        chk("midrst_in_ready2", in_ready, 0);
        chk("midrst_out_valid", out_valid, 0);
        in_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        make_clean(1'b1);
        run_frame(-1);
        chk("midrst_clean", cap_det, 0);

        // Random frames with 0, 1 or 2 injected faults
        for (int k = 0; k < 12; k++) begin
            int ninj;
            make_clean(1'b1);
            ninj = $urandom_range(0, 2);
            for (int i = 0; i < ninj; i++) begin
                int rr = $urandom_range(0, N);
                int cc = $urandom_range(0, N);
                frame[rr][cc] = m8(frame[rr][cc] + $urandom_range(1, 255));
            end
            run_frame((k % 3 == 0) ? $urandom_range(0, N) : -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire

// File: doc/abft_fc_verifier.md
ABFT_FC_VERIFIER -- requirements
Module: abft_fc_verifier

Interface
REQ-001 SHALL have parameter N, default 32: data elements per row; a frame is (N+1)x(N+1) full-checksum matrix Cf.
REQ-002 SHALL have parameter W, default 32: element width in bits; all arithmetic is modulo 2^W.
REQ-003 SHALL use one clock; reset is synchronous and active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 in_valid  input  1  in_row carries one Cf row.
REQ-007 in_ready  output  1  block accepts a row this cycle.
REQ-008 in_row  input  (N+1)*W  element j at bits [j*W +: W]; element N is the row checksum.
REQ-009 out_valid  output  1  out_row holds a verified row.
REQ-010 out_ready  input  1  downstream accepts out_row.
REQ-011 out_row  output  (N+1)*W  verified, possibly corrected, row; same packing as in_row.
REQ-012 status_valid  output  1  err_* fields valid for the frame being drained.
REQ-013 err_detected / err_corrected / err_uncorrectable  output  1 each  frame classification.
REQ-014 err_row, err_col  output  $clog2(N+1) each  location of the single faulty element.

Function
REQ-015 SHALL accept rows 0..N in order; row N is the column-checksum row. No framing signal; row index comes from an internal counter.
REQ-016 SHALL implement states COLLECT, CHECK, DRAIN; in_ready=1 only in COLLECT; out_valid=1 only in DRAIN.
REQ-017 COLLECT: on each in_valid&&in_ready, SHALL store the row in an (N+1)-deep buffer. For every row r it SHALL compute rd[r] = sum(elements 0..N-1) - element N and set row-mismatch bit r if rd[r]!=0. For rows 0..N-1 it SHALL add each element into column accumulator acc[c].
REQ-018 COLLECT SHALL transition to CHECK on acceptance of row N. At that point cd[c] = acc[c] - row N element c, and column-mismatch bit c is set if cd[c]!=0, for c=0..N.
REQ-019 CHECK SHALL last exactly one cycle and classify the frame:
- no mismatch bits -> clean;
- exactly one row bit (r) and exactly one column bit (c) -> single error at (r,c);
- any other pattern -> uncorrectable.
REQ-020 Correction value e SHALL be rd[r] if c<N, else cd[c] if r<N, else -rd[r]; the corrected element is stored minus e, modulo 2^W.
REQ-021 DRAIN SHALL present buffer rows 0..N in order; out_row/out_valid SHALL stay stable while out_valid&&!out_ready. Only element (r,c) of row r is replaced, and only for a correctable single error.
REQ-022 After the row-N output handshake, the block SHALL return to COLLECT with counters, accumulators and mismatch bits cleared; in_ready SHALL be 1 the next cycle.
REQ-023 Latency: row N accepted at cycle t -> CHECK at t+1 -> out_valid=1 at t+2; minimum frame time is 2(N+1)+1 cycles.
REQ-024 status_valid SHALL be 1 throughout DRAIN, with err_* held constant.
- clean: all err_* = 0.
- single error: err_detected=1, err_row=r, err_col=c.
- uncorrectable: err_detected=1, err_uncorrectable=1, err_row=err_col=0, rows passed unmodified.
REQ-025 in_valid during CHECK/DRAIN SHALL be ignored (not accepted); out_ready outside DRAIN SHALL have no effect.

Reset
REQ-026 rst SHALL, at the next clock edge, force state COLLECT, clear all counters, accumulators, mismatch bits and err_*, and drive in_ready, out_valid and status_valid to 0 while rst is high. Buffer contents need no reset.
REQ-027 rst mid-frame (any state) SHALL discard the partial frame; the first row accepted after reset is row 0.

Configuration
REQ-028 Macro ABFT_CORRECT_EN: when defined, a single error SHALL be corrected per REQ-020 and err_corrected=1.
REQ-029 Without ABFT_CORRECT_EN, the block is detect-only: location is still reported, out_row is never modified, err_corrected=0, and err_uncorrectable=0 for a single error.

Structure
REQ-030 Package abft_pkg SHALL hold default N/W constants, the state enum (COLLECT/CHECK/DRAIN) and the index-width function.
REQ-031 One sub-module abft_row_checker SHALL compute rd and the mismatch bit for one row, combinationally.

Verification (N=4, W=8 unless stated)
REQ-032 Clean frame, rows {1,2,3,4,10}, {5,6,7,8,26}, ..., correct checksum row -> all err_*=0; out rows equal input rows; out_valid 2 cycles after row 4 accepted.
REQ-033 Element (1,2) changed 7->9 -> err_detected=1, err_row=1, err_col=2; with ABFT_CORRECT_EN out element=7 and err_corrected=1; without it, out element=9 and err_corrected=0.
REQ-034 Checksum (4,4) corrupted by +3, and separately (2,4) corrupted -> corner and checksum-column rules of REQ-020 restore the original values.
REQ-035 Errors at (0,1) and (2,3) -> err_uncorrectable=1, data unmodified; wrap case with element 250 and error +10 -> value 4 corrected back to 250.
REQ-036 out_ready held low 5 cycles mid-drain -> out_row stable; rst asserted after row 2 accepted -> in_ready=0 during rst, then a fresh full frame verifies clean.
